// File: rtl/fan_pwm_ramp_pkg.sv
// Shared types and elaboration-time helpers for the fan PWM controller.
package fan_pwm_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        RAMP,
        HOLD
    } fan_state_e;

    function automatic int unsigned period_cycles(input int unsigned clk_hz, input int unsigned pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

    function automatic int unsigned step_cycles(input int unsigned period, input int unsigned duty_max);
        return period / duty_max;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fan_pwm_ramp_if.sv
// Board-side signal bundle of the fan controller: switch setting and tach in, PWM and status out.
interface fan_pwm_ramp_if #(
    parameter int unsigned DutyWidth = 4
);
    logic [DutyWidth-1:0] fan_sw_i;
    logic                 tach_i;
    logic                 fan_pwm_o;
    logic [DutyWidth-1:0] duty_o;
    logic                 busy_o;
    logic [15:0]          tach_cnt_o;
    logic                 stall_o;

    modport master (
        output fan_sw_i, tach_i,
        input  fan_pwm_o, duty_o, busy_o, tach_cnt_o, stall_o
    );

    modport slave (
        input  fan_sw_i, tach_i,
        output fan_pwm_o, duty_o, busy_o, tach_cnt_o, stall_o
    );
endinterface

// File: rtl/fan_pwm_ramp_tach_meter.sv
// Two-flop synchronizer cell and the windowed tach edge counter with stall detection.
module fan_sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);
    logic [Width-1:0] meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module fan_tach_meter
    import fan_pwm_ramp_pkg::*;
#(
    parameter int unsigned TachWindowCycles = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tach,
    input  logic        duty_nz,
    input  logic        kick_active,
    output logic [15:0] tach_cnt,
    output logic        stall
);
    localparam int unsigned WinW = cnt_width(TachWindowCycles);

    logic            tach_s;
    logic            tach_prev;
    logic            fall;
    logic            win_end;
    logic [WinW-1:0] wcnt;
    logic [15:0]     ecnt;
    logic            kick_seen;

    fan_sync2 #(.Width(1)) u_tach_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (tach),
        .q     (tach_s)
    );

    assign fall    = tach_prev & ~tach_s;
    assign win_end = (wcnt == WinW'(TachWindowCycles - 1));

    // A falling edge on the window-end cycle seeds the new window's count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tach_prev <= 1'b0;
            wcnt      <= '0;
            ecnt      <= '0;
            kick_seen <= 1'b0;
            tach_cnt  <= '0;
            stall     <= 1'b0;
        end else begin
            tach_prev <= tach_s;
            if (win_end) begin
                wcnt      <= '0;
                tach_cnt  <= ecnt;
                ecnt      <= fall ? 16'd1 : '0;
                stall     <= (ecnt == '0) && duty_nz && !(kick_seen || kick_active);
                kick_seen <= 1'b0;
            end else begin
                wcnt <= wcnt + WinW'(1);
                if (fall && (ecnt != 16'hFFFF)) begin
                    ecnt <= ecnt + 16'd1;
                end
                kick_seen <= kick_seen | kick_active;
            end
        end
    end
endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan PWM controller: kick-start at full speed, slew-limited duty ramp, tach-based stall monitor.
module fan_pwm_ramp
    import fan_pwm_ramp_pkg::*;
#(
    parameter int unsigned ClkFreqHz        = 50_000_000,
    parameter int unsigned PwmFreqHz        = 25_000,
    parameter int unsigned DutyWidth        = 4,
    parameter int unsigned KickPeriods      = 200,
    parameter int unsigned RampStepPeriods  = 4,
    parameter int unsigned TachWindowCycles = 50_000_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fan_pwm_ramp_if.slave bus
);
    localparam int unsigned DutyMax      = (1 << DutyWidth) - 1;
    localparam int unsigned PeriodCycles = period_cycles(ClkFreqHz, PwmFreqHz);
    localparam int unsigned StepCycles   = step_cycles(PeriodCycles, DutyMax);
    localparam int unsigned PcntW        = cnt_width(PeriodCycles);
    localparam int unsigned HighW        = cnt_width(PeriodCycles + 1);
    localparam int unsigned KcntW        = cnt_width(KickPeriods);
    localparam int unsigned RcntW        = cnt_width(RampStepPeriods);

    fan_state_e           state_q, state_d;
    logic [DutyWidth-1:0] tgt;
    logic [DutyWidth-1:0] duty_q, duty_d, stepped;
    logic [KcntW-1:0]     kcnt_q, kcnt_d;
    logic [RcntW-1:0]     rcnt_q, rcnt_d;
    logic [PcntW-1:0]     pcnt_q;
    logic [HighW-1:0]     high_q, high_d;
    logic                 pwm_q;
    logic                 bnd;

    fan_sync2 #(.Width(DutyWidth)) u_sw_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (bus.fan_sw_i),
        .q     (tgt)
    );

    assign bnd = (pcnt_q == PcntW'(PeriodCycles - 1));

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        kcnt_d  = kcnt_q;
        rcnt_d  = rcnt_q;
        stepped = duty_q;
        if (bnd) begin
            unique case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (tgt != '0) begin
                        state_d = KICK;
                        kcnt_d  = '0;
                    end
                end
                KICK: begin
                    if ((tgt == '0) || (kcnt_q == KcntW'(KickPeriods - 1))) begin
                        duty_d  = DutyWidth'(DutyMax);
                        rcnt_d  = '0;
                        state_d = RAMP;
                    end else begin
                        kcnt_d = kcnt_q + KcntW'(1);
                    end
                end
                RAMP: begin
                    if (rcnt_q == RcntW'(RampStepPeriods - 1)) begin
                        rcnt_d = '0;
                        if (duty_q < tgt) begin
                            stepped = duty_q + DutyWidth'(1);
                        end else if (duty_q > tgt) begin
                            stepped = duty_q - DutyWidth'(1);
                        end
                    end else begin
                        rcnt_d = rcnt_q + RcntW'(1);
                    end
                    duty_d = stepped;
                    if (stepped == '0) begin
                        state_d = IDLE;
                    end else if (stepped == tgt) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (duty_q != tgt) begin
                        state_d = RAMP;
                        rcnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // High time follows the duty applied for the coming period, so duty_o and the PWM agree.
    always_comb begin
        if (duty_d == DutyWidth'(DutyMax)) begin
            high_d = HighW'(PeriodCycles);
        end else begin
            high_d = HighW'(duty_d * StepCycles);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            duty_q  <= '0;
            kcnt_q  <= '0;
            rcnt_q  <= '0;
            pcnt_q  <= '0;
            high_q  <= '0;
            pwm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            kcnt_q  <= kcnt_d;
            rcnt_q  <= rcnt_d;
            pcnt_q  <= bnd ? '0 : pcnt_q + PcntW'(1);
            if (bnd) begin
                high_q <= high_d;
            end
            if (state_q == KICK) begin
                pwm_q <= 1'b1;
            end else if (state_q == IDLE) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= (HighW'(pcnt_q) < high_q);
            end
        end
    end

    fan_tach_meter #(.TachWindowCycles(TachWindowCycles)) u_tach (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tach        (bus.tach_i),
        .duty_nz     (duty_q != '0),
        .kick_active (state_q == KICK),
        .tach_cnt    (bus.tach_cnt_o),
        .stall       (bus.stall_o)
    );

    assign bus.fan_pwm_o = pwm_q;
    assign bus.duty_o    = duty_q;
    assign bus.busy_o    = (state_q == KICK) || (state_q == RAMP);
endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Bench for fan_pwm_ramp: setting table with a duty-step scoreboard, kick abort and tach/stall sequences.
module tb_fan_pwm_ramp;
    localparam int PER = 16;
    localparam int WIN = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fan_pwm_ramp_if #(.DutyWidth(4)) bus ();

    fan_pwm_ramp #(
        .ClkFreqHz        (1600),
        .PwmFreqHz        (100),
        .DutyWidth        (4),
        .KickPeriods      (2),
        .RampStepPeriods  (1),
        .TachWindowCycles (160)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int duty;
        int gap;
    } step_t;

    typedef struct {
        logic [3:0] sw;
        bit         kick;
        int         final_duty;
        int         high;
    } vec_t;

    step_t exp_q[$];
    vec_t  vecs[6];
    int    checks = 0;
    int    errors = 0;
    int    model_duty = 0;
    int    cyc = 0;
    bit    tach_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected duty_o sequence for a new setting: gap 0 means the interval is not checked.
    task automatic push_steps(input int to);
        int d;
        int g;
        d = model_duty;
        g = 0;
        if (d == 0 && to != 0) begin
            exp_q.push_back('{15, 0});
            d = 15;
            g = PER;
        end
        while (d != to) begin
            d = (d < to) ? d + 1 : d - 1;
            exp_q.push_back('{d, g});
            g = PER;
        end
        model_duty = to;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic measure_high(output int h);
        h = 0;
        repeat (PER) begin
            @(negedge clk);
            h += int'(bus.fan_pwm_o);
        end
    endtask

    // Counts KICK samples (busy with zero duty); the first sample still shows the registered IDLE low.
    task automatic count_kick(output int kc, output int kh);
        kc = 0;
        kh = 0;
        while (bus.busy_o && bus.duty_o == 4'd0 && kc < 200) begin
            if (kc > 0) kh += int'(bus.fan_pwm_o);
            kc++;
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v);
        bit ok;
        int kc;
        int kh;
        int h;
        bus.fan_sw_i = v.sw;
        push_steps(int'(v.sw));
        if (v.kick) begin
            wait_busy(ok);
            check("kick_start", int'(ok), 1);
            count_kick(kc, kh);
            check("kick_cycles", kc, 2 * PER);
            check("kick_pwm_high", kh, 2 * PER - 1);
            check("busy_in_ramp", int'(bus.busy_o), 1);
        end
        drain("steps_done");
        repeat (40) @(negedge clk);
        check("final_duty", int'(bus.duty_o), v.final_duty);
        check("busy_settled", int'(bus.busy_o), 0);
        measure_high(h);
        check("pwm_high_per_period", h, v.high);
    endtask

    initial begin
        bit ok;
        int kc;
        int kh;
        int h;
        int p;
        int dcyc;
        int w;

        vecs[0] = '{4'd8,  1'b1, 8,  8};
        vecs[1] = '{4'd15, 1'b0, 15, 16};
        vecs[2] = '{4'd8,  1'b0, 8,  8};
        vecs[3] = '{4'd0,  1'b0, 0,  0};
        vecs[4] = '{4'd3,  1'b1, 3,  3};
        vecs[5] = '{4'd0,  1'b0, 0,  0};

        rst = 1'b1;
        bus.fan_sw_i = 4'd0;
        bus.tach_i = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_pwm", int'(bus.fan_pwm_o), 1);
        check("rst_duty", int'(bus.duty_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_tach_cnt", int'(bus.tach_cnt_o), 0);
        check("rst_stall", int'(bus.stall_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pwm", int'(bus.fan_pwm_o), 0);
        check("idle_duty", int'(bus.duty_o), 0);
        check("idle_busy", int'(bus.busy_o), 0);
        check("idle_stall", int'(bus.stall_o), 0);

        fork
            begin : duty_monitor
                int last;
                int gap;
                step_t e;
                last = 0;
                gap = 0;
                forever begin
                    @(negedge clk);
                    gap++;
                    if (int'(bus.duty_o) != last) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_duty_change", int'(bus.duty_o), last);
                        end else begin
                            e = exp_q.pop_front();
                            check("duty_step", int'(bus.duty_o), e.duty);
                            if (e.gap != 0) check("step_gap", gap, e.gap);
                        end
                        last = int'(bus.duty_o);
                        gap = 0;
                    end
                end
            end
            begin : tach_gen
                int tc;
                tc = 0;
                forever begin
                    @(negedge clk);
                    if (tach_en) begin
                        tc = (tc + 1) % 40;
                        bus.tach_i = (tc >= 35) ? 1'b0 : 1'b1;
                    end else begin
                        bus.tach_i = 1'b1;
                    end
                end
            end
        join_none

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        // Setting withdrawn during the first kick period: exit at that boundary from full duty.
        bus.fan_sw_i = 4'd5;
        wait_busy(ok);
        check("abort_kick_start", int'(ok), 1);
        bus.fan_sw_i = 4'd0;
        exp_q.push_back('{15, 0});
        for (int d = 14; d >= 0; d--) exp_q.push_back('{d, PER});
        model_duty = 0;
        count_kick(kc, kh);
        check("abort_kick_cycles", kc, PER);
        drain("abort_steps_done");
        repeat (40) @(negedge clk);
        check("abort_final_duty", int'(bus.duty_o), 0);
        check("abort_busy", int'(bus.busy_o), 0);
        measure_high(h);
        check("abort_pwm_high", h, 0);

        apply(vecs[0]);
        tach_en = 1'b1;
        repeat (3 * WIN + 20) @(negedge clk);
        check("tach_cnt_running", int'(bus.tach_cnt_o), 4);
        check("stall_running", int'(bus.stall_o), 0);

        tach_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3 * WIN; i++) begin
            @(negedge clk);
            if (bus.tach_cnt_o == 16'd0) begin
                ok = 1'b1;
                break;
            end
        end
        p = cyc;
        check("tach_cnt_quiet", int'(ok), 1);
        check("stall_quiet", int'(bus.stall_o), 1);

        // Start a kick right after a known window end so the next window end falls in the ramp.
        bus.fan_sw_i = 4'd0;
        push_steps(0);
        drain("down_steps_done");
        for (int i = 0; i < 2 * WIN && ((cyc - p) % WIN) != 1; i++) @(negedge clk);
        check("window_phase_found", (cyc - p) % WIN, 1);
        bus.fan_sw_i = 4'd3;
        push_steps(3);
        dcyc = cyc;
        w = dcyc - 1 + WIN;
        for (int i = 0; i < 2 * WIN && cyc < w; i++) @(negedge clk);
        check("duty_nz_at_kick_window_end", int'(bus.duty_o != 4'd0), 1);
        check("stall_kick_window", int'(bus.stall_o), 0);
        for (int i = 0; i < 2 * WIN && cyc < w + WIN; i++) @(negedge clk);
        check("stall_after_kick_window", int'(bus.stall_o), 1);
        check("tach_cnt_after_kick_window", int'(bus.tach_cnt_o), 0);
        drain("final_steps_done");
        check("final_hold_duty", int'(bus.duty_o), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
